mixcol_addkey_stage: RTL

// - Consumes the 128-bit ShiftRows output. Applies MixColumns, or bypasses it on the final round.
// - XORs the round key, then presents the next round state through a valid/ready skid buffer.
// - Sits between shiftrows and the next round's SubBytes/state register in the iterative AES datapath.

---
 rtl/mixcol_addkey_stage_pkg.sv | 37 +++
 rtl/mixcol_addkey_stage_if.sv | 27 ++
 rtl/mixcol_addkey_stage_mixcolumns_col.sv | 23 ++
 rtl/mixcol_addkey_stage.sv | 96 +++++++++
 4 files changed

// File: rtl/mixcol_addkey_stage_pkg.sv
// Shared types and GF(2^8) helpers for the MixColumns/AddRoundKey stage.
// State layout is column-major: column c = [127-32c -: 32],
// row r within a column = [31-8r -: 8].
package mixcol_addkey_stage_pkg;

    localparam int         AES_BLOCK_W  = 128;
    localparam logic [7:0] AES_RED_POLY = 8'h1B;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

    typedef struct packed {
        logic                   last;
        logic [AES_BLOCK_W-1:0] data;
    } beat_t;

    // Multiply by x modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? AES_RED_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul3(input logic [7:0] a);
        return xtime(a) ^ a;
    endfunction

    function automatic logic [31:0] get_col(input logic [AES_BLOCK_W-1:0] s, input int c);
        return s[AES_BLOCK_W-1-32*c -: 32];
    endfunction

    function automatic logic [7:0] get_byte(input logic [31:0] col, input int r);
        return col[31-8*r -: 8];
    endfunction

endpackage

// File: rtl/mixcol_addkey_stage_if.sv
// Handshake bundle for the stage: upstream beat (data, key, last) with
// valid/ready, and the downstream result beat with valid/ready.
//   slave  : view taken by the stage itself
//   master : view taken by whatever drives and consumes the stage
interface mixcol_addkey_stage_if;
    import mixcol_addkey_stage_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [AES_BLOCK_W-1:0] in_data;
    logic [AES_BLOCK_W-1:0] in_key;
    logic                   in_last;
    logic                   out_valid;
    logic                   out_ready;
    logic [AES_BLOCK_W-1:0] out_data;
    logic                   out_last;

    modport slave (
        input  in_valid, in_data, in_key, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, in_key, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/mixcol_addkey_stage_mixcolumns_col.sv
// MixColumns on one 32-bit column, purely combinational.
//   col_i : input column  {a0,a1,a2,a3}, a0 in [31:24]
//   col_o : output column {b0,b1,b2,b3}
module mixcolumns_col
    import mixcol_addkey_stage_pkg::*;
(
    input  logic [31:0] col_i,
    output logic [31:0] col_o
);
    logic [7:0] a0, a1, a2, a3;

    assign a0 = get_byte(col_i, 0);
    assign a1 = get_byte(col_i, 1);
    assign a2 = get_byte(col_i, 2);
    assign a3 = get_byte(col_i, 3);

    assign col_o = {
        xtime(a0)   ^ gf_mul3(a1) ^ a2          ^ a3,
        a0          ^ xtime(a1)   ^ gf_mul3(a2) ^ a3,
        a0          ^ a1          ^ xtime(a2)   ^ gf_mul3(a3),
        gf_mul3(a0) ^ a1          ^ a2          ^ xtime(a3)
    };
endmodule

// File: rtl/mixcol_addkey_stage.sv
// AES round tail: MixColumns (bypassed on the final round when enabled),
// AddRoundKey, then a two-entry skid buffer so in_ready is a pure function
// of the state register and never of out_ready.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave view of the in/out handshake bundle
// Parameters: BYPASS_EN (1 = in_last skips MixColumns), SKID_DEPTH (must be 2).
module mixcol_addkey_stage
    import mixcol_addkey_stage_pkg::*;
#(
    parameter int BYPASS_EN  = 1,
    parameter int SKID_DEPTH = 2
) (
    input logic                  clk,
    input logic                  rst_n,
    mixcol_addkey_stage_if.slave bus
);
    if (SKID_DEPTH != 2) begin : g_bad_depth
        $error("mixcol_addkey_stage: SKID_DEPTH must be 2");
    end

    logic [AES_BLOCK_W-1:0] mc_data;
    beat_t                  f_beat;
    skid_state_e            state_q, state_d;
    beat_t                  main_q, main_d;
    beat_t                  skid_q, skid_d;
    logic                   in_ready, out_valid, accept, pop;

    for (genvar c = 0; c < 4; c++) begin : g_col
        mixcolumns_col u_col (
            .col_i (get_col(bus.in_data, c)),
            .col_o (mc_data[AES_BLOCK_W-1-32*c -: 32])
        );
    end

    always_comb begin
        f_beat.last = bus.in_last;
        f_beat.data = (((BYPASS_EN != 0) && bus.in_last) ? bus.in_data : mc_data) ^ bus.in_key;
    end

    assign accept = bus.in_valid & in_ready;
    assign pop    = out_valid & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Registers only load on an accept or a skid->main move, so an idle
    // (possibly X) in_data never reaches out_data.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    main_d  = f_beat;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && pop) begin
                    main_d = f_beat;
                end else if (accept) begin
                    skid_d  = f_beat;
                    state_d = ST_FULL;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        in_ready     = (state_q != ST_FULL);
        out_valid    = (state_q != ST_EMPTY);
        bus.in_ready  = in_ready;
        bus.out_valid = out_valid;
        bus.out_data  = main_q.data;
        bus.out_last  = main_q.last;
    end
endmodule
